// File: rtl/hamming_serial_rx_if.sv
// Bus bundle for the Hamming(7,4) serial receiver: serial input strobe side and
// the valid/ready parallel output side, plus status pulses and error count.
interface hamming_serial_rx_if #(
  parameter int width = 8
);
  localparam int BLOCKS = width / 4;

  logic              serial_in;
  logic              serial_valid;
  logic              frame_start;
  logic [width-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic [BLOCKS-1:0] out_corrected;
  logic              overrun;
  logic              sync_err;
  logic [7:0]        err_count;

  modport master (
    output serial_in, serial_valid, frame_start, out_ready,
    input  out_data, out_valid, out_corrected, overrun, sync_err, err_count
  );

  modport slave (
    input  serial_in, serial_valid, frame_start, out_ready,
    output out_data, out_valid, out_corrected, overrun, sync_err, err_count
  );
endinterface

// File: rtl/hamming_serial_rx.sv
// Hamming(7,4) serial frame receiver with single-bit correction and a 1-entry output buffer.
// Optional saturating corrected-block counter enabled by defining HAMMING_ERR_CNT_EN.
module hamming_serial_rx #(
  parameter int width = 8
) (
  input  logic                clk,
  input  logic                rst,
  hamming_serial_rx_if.slave  bus
);
  localparam int BLOCKS = width / 4;
  localparam int N      = 7 * BLOCKS;
  localparam int CW     = $clog2(N + 1);

  typedef enum logic [0:0] {IDLE, RECV} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N-1:0]      shreg_q, shreg_d;
  logic [width-1:0]  data_q, data_d, data_new;
  logic [BLOCKS-1:0] corr_q, corr_d, corr_new;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              sync_err_q, sync_err_d;
  logic              frame_done;
`ifdef HAMMING_ERR_CNT_EN
  logic [7:0]        err_q, err_d;
`endif

  // Per-block syndrome decode; result packs {corrected flags, data}.
  function automatic logic [BLOCKS+width-1:0] decode(input logic [N-1:0] f);
    logic [width-1:0]  d;
    logic [BLOCKS-1:0] c;
    logic [3:0]        nib;
    logic [2:0]        syn;
    d = '0;
    c = '0;
    for (int b = 0; b < BLOCKS; b++) begin
      nib    = f[7*b +: 4];
      syn[0] = f[7*b+4] ^ nib[3] ^ nib[2] ^ nib[0];
      syn[1] = f[7*b+5] ^ nib[3] ^ nib[1] ^ nib[0];
      syn[2] = f[7*b+6] ^ nib[2] ^ nib[1] ^ nib[0];
      case (syn)
        3'b101:  nib[2] = ~nib[2];
        3'b111:  nib[0] = ~nib[0];
        3'b011:  nib[3] = ~nib[3];
        3'b110:  nib[1] = ~nib[1];
        default: ;
      endcase
      d[4*b +: 4] = nib;
      c[b]        = |syn;
    end
    return {c, d};
  endfunction

`ifdef HAMMING_ERR_CNT_EN
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [BLOCKS-1:0] c);
    logic [8:0] s;
    s = {1'b0, a} + 9'($countones(c));
    return s[8] ? 8'hFF : s[7:0];
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    corr_d     = corr_q;
    valid_d    = valid_q;
    overrun_d  = 1'b0;
    sync_err_d = 1'b0;
    frame_done = 1'b0;
`ifdef HAMMING_ERR_CNT_EN
    err_d      = err_q;
`endif

    // frame_start always restarts, even mid-frame; plain bits only count inside a frame
    if (bus.serial_valid) begin
      if (bus.frame_start) begin
        shreg_d    = {bus.serial_in, shreg_q[N-1:1]};
        state_d    = RECV;
        cnt_d      = CW'(1);
        sync_err_d = (state_q == RECV);
      end else if (state_q == RECV) begin
        shreg_d = {bus.serial_in, shreg_q[N-1:1]};
        if (cnt_q == CW'(N - 1)) begin
          state_d    = IDLE;
          cnt_d      = '0;
          frame_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    {corr_new, data_new} = decode(shreg_d);

    if (valid_q && bus.out_ready) valid_d = 1'b0;

    // A full, unaccepted buffer keeps its word; otherwise the new frame overwrites it
    if (frame_done) begin
      if (valid_q && !bus.out_ready) begin
        overrun_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = data_new;
        corr_d  = corr_new;
`ifdef HAMMING_ERR_CNT_EN
        err_d   = sat_add(err_q, corr_new);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      corr_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      sync_err_q <= 1'b0;
`ifdef HAMMING_ERR_CNT_EN
      err_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      corr_q     <= corr_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      sync_err_q <= sync_err_d;
`ifdef HAMMING_ERR_CNT_EN
      err_q      <= err_d;
`endif
    end
  end

  assign bus.out_data      = data_q;
  assign bus.out_corrected = corr_q;
  assign bus.out_valid     = valid_q;
  assign bus.overrun       = overrun_q;
  assign bus.sync_err      = sync_err_q;
`ifdef HAMMING_ERR_CNT_EN
  assign bus.err_count     = err_q;
`else
  assign bus.err_count     = 8'h00;
`endif

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Bench for hamming_serial_rx: directed frames plus randomized traffic checked
// every cycle against a nearest-codeword reference model.
`timescale 1ns/1ps
module tb_hamming_serial_rx;
  localparam int W = 8;
  localparam int B = W / 4;
  localparam int N = 7 * B;

  typedef struct packed {
    logic [W-1:0] data;
    logic [B-1:0] corr;
  } dec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   ovr_pulses = 0;
  int   sync_pulses = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hamming_serial_rx_if #(.width(W)) bus ();
  hamming_serial_rx #(.width(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Codeword layout: bits 0..3 = d0..d3, bits 4..6 = p1,p2,p3
  function automatic logic [6:0] enc(input logic [3:0] d);
    return {d[2] ^ d[1] ^ d[0], d[3] ^ d[1] ^ d[0], d[3] ^ d[2] ^ d[0], d};
  endfunction

  function automatic logic [N-1:0] enc_word(input logic [W-1:0] d);
    logic [N-1:0] f;
    for (int b = 0; b < B; b++) f[7*b +: 7] = enc(d[4*b +: 4]);
    return f;
  endfunction

  // Reference decode: pick the data nibble whose codeword lies within distance 1
  function automatic dec_t dec(input logic [N-1:0] f);
    dec_t r;
    r = '0;
    for (int b = 0; b < B; b++) begin
      for (int v = 0; v < 16; v++) begin
        if ($countones(enc(4'(v)) ^ f[7*b +: 7]) <= 1) begin
          r.data[4*b +: 4] = 4'(v);
          r.corr[b]        = (enc(4'(v)) != f[7*b +: 7]);
        end
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] put_bit(input logic [N-1:0] f, input int k, input logic b);
    f[k] = b;
    return f;
  endfunction

  function automatic int next_err(input int e, input logic [B-1:0] c);
    return (e + $countones(c) > 255) ? 255 : e + $countones(c);
  endfunction

  // Reference model state
  logic         m_infr;
  int           m_cnt;
  logic [N-1:0] m_frame;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [B-1:0] m_corr;
  logic         m_ovr;
  logic         m_sync;
  int           m_err;
  logic         m_done;

  assign m_done = bus.serial_valid && !bus.frame_start && m_infr && (m_cnt == N - 1);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_infr  <= 1'b0;
      m_cnt   <= 0;
      m_frame <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_corr  <= '0;
      m_ovr   <= 1'b0;
      m_sync  <= 1'b0;
      m_err   <= 0;
    end else begin
      m_sync <= bus.serial_valid && bus.frame_start && m_infr;
      if (bus.serial_valid && bus.frame_start) begin
        m_infr  <= 1'b1;
        m_cnt   <= 1;
        m_frame <= N'(bus.serial_in);
      end else if (bus.serial_valid && m_infr) begin
        m_frame[m_cnt] <= bus.serial_in;
        m_cnt          <= (m_cnt == N - 1) ? 0 : m_cnt + 1;
        if (m_cnt == N - 1) m_infr <= 1'b0;
      end
      m_ovr <= m_done && m_valid && !bus.out_ready;
      if (m_done && !(m_valid && !bus.out_ready)) begin
        m_valid <= 1'b1;
        m_data  <= dec(put_bit(m_frame, N - 1, bus.serial_in)).data;
        m_corr  <= dec(put_bit(m_frame, N - 1, bus.serial_in)).corr;
        m_err   <= next_err(m_err, dec(put_bit(m_frame, N - 1, bus.serial_in)).corr);
      end else if (m_valid && bus.out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  function automatic int exp_err();
`ifdef HAMMING_ERR_CNT_EN
    return m_err;
`else
    return 0;
`endif
  endfunction

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      check("out_data", 32'(bus.out_data), 32'(m_data));
      check("out_corrected", 32'(bus.out_corrected), 32'(m_corr));
    end
    check("overrun", 32'(bus.overrun), 32'(m_ovr));
    check("sync_err", 32'(bus.sync_err), 32'(m_sync));
    check("err_count", 32'(bus.err_count), 32'(exp_err()));
    if (bus.overrun === 1'b1) ovr_pulses <= ovr_pulses + 1;
    if (bus.sync_err === 1'b1) sync_pulses <= sync_pulses + 1;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.serial_valid = 1'b0;
      bus.frame_start  = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [N-1:0] f, input int from, input int to);
    for (int k = from; k <= to; k++) begin
      @(posedge clk); #1;
      bus.serial_in    = f[k];
      bus.serial_valid = 1'b1;
      bus.frame_start  = (k == from);
    end
  endtask

  task automatic send_frame(input logic [N-1:0] f);
    send_bits(f, 0, N - 1);
    @(posedge clk); #1;
    bus.serial_valid = 1'b0;
    bus.frame_start  = 1'b0;
  endtask

  task automatic expect_word(input string name, input logic [W-1:0] d, input logic [B-1:0] c);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_data"}, 32'(bus.out_data), 32'(d));
    check({name, "_corr"}, 32'(bus.out_corrected), 32'(c));
  endtask

  logic [W-1:0] rd;
  logic [N-1:0] rf;
  int           ekind, o0, s0, e1, e2;

  initial begin
    bus.serial_in    = 1'b0;
    bus.serial_valid = 1'b0;
    bus.frame_start  = 1'b0;
    bus.out_ready    = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;

    // Pin the reference model to hand-worked values
    check("model_enc5", 32'(enc(4'h5)), 32'h25);
    check("model_encA", 32'(enc(4'hA)), 32'h5A);
    check("model_frame", 32'(enc_word(8'hA5)), 32'h2D25);
    check("model_2D21", 32'(dec(14'h2D21)), {22'd0, 8'hA5, 2'b01});
    check("model_2525", 32'(dec(14'h2525)), {22'd0, 8'hA5, 2'b10});
    check("model_2D26", 32'(dec(14'h2D26)), {22'd0, 8'hA6, 2'b01});

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_corr", 32'(bus.out_corrected), 32'd0);
    check("rst_err", 32'(bus.err_count), 32'd0);
    rst = 1'b1;
    idle(2);

    send_frame(14'h2D25);  expect_word("clean", 8'hA5, 2'b00);
    send_frame(14'h2D21);  expect_word("d2flip", 8'hA5, 2'b01);
    send_frame(14'h2525);  expect_word("p1flip", 8'hA5, 2'b10);
    send_frame(14'h2D26);  expect_word("double", 8'hA6, 2'b01);
    idle(2);

    // Stalled consumer: second frame is dropped
    bus.out_ready = 1'b0;
    o0 = ovr_pulses;
    send_frame(14'h2D25);
    send_frame(14'h2D21);
    check("ovr_pulse", 32'(bus.overrun), 32'd1);
    expect_word("ovr_hold", 8'hA5, 2'b00);
    idle(3);
    check("ovr_count", 32'(ovr_pulses - o0), 32'd1);
    expect_word("ovr_hold2", 8'hA5, 2'b00);
    bus.out_ready = 1'b1;
    idle(1);
    check("ovr_drain", 32'(bus.out_valid), 32'd0);

    // Restart mid-frame
    s0 = sync_pulses;
    send_bits(14'h2D25, 0, 4);
    send_frame(14'h2D25);
    expect_word("sync", 8'hA5, 2'b00);
    idle(2);
    check("sync_count", 32'(sync_pulses - s0), 32'd1);

    // Reset mid-frame while a word is held
    bus.out_ready = 1'b0;
    send_frame(14'h2D21);
    send_bits(14'h2D25, 0, 8);
    @(posedge clk); #1;
    bus.serial_valid = 1'b0;
    bus.frame_start  = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data", 32'(bus.out_data), 32'd0);
    check("mid_rst_corr", 32'(bus.out_corrected), 32'd0);
    check("mid_rst_err", 32'(bus.err_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    idle(1);
    send_frame(14'h2D25);
    expect_word("post_rst", 8'hA5, 2'b00);
    idle(2);

    // Error counter saturation (or tie-off when the counter is not built)
`ifdef HAMMING_ERR_CNT_EN
    repeat (300) send_bits(14'h2D21, 0, N - 1);
    idle(2);
    check("err_sat", 32'(bus.err_count), 32'd255);
`else
    repeat (20) send_bits(14'h2D21, 0, N - 1);
    idle(2);
    check("err_tied", 32'(bus.err_count), 32'd0);
`endif

    // Randomized traffic with gaps, stalls, restarts and 0/1/2-bit errors
    for (int f = 0; f < 300; f++) begin
      rd    = 8'($urandom);
      rf    = enc_word(rd);
      ekind = $urandom_range(0, 3);
      e1    = $urandom_range(0, N - 1);
      e2    = (e1 + $urandom_range(1, N - 1)) % N;
      if (ekind >= 2) rf[e1] = ~rf[e1];
      if (ekind == 3) rf[e2] = ~rf[e2];
      for (int k = 0; k < N; k++) begin
        while ($urandom_range(0, 4) == 0) begin
          @(posedge clk); #1;
          bus.serial_valid = 1'b0;
          bus.frame_start  = 1'($urandom_range(0, 1));
          bus.out_ready    = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        bus.serial_in    = rf[k];
        bus.serial_valid = 1'b1;
        bus.frame_start  = (k == 0) || ($urandom_range(0, 59) == 0);
        bus.out_ready    = ($urandom_range(0, 3) != 0);
      end
    end
    bus.out_ready = 1'b1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
